// File: rtl/uart_tx_mmio_pkg.sv
// uart_tx_mmio_pkg
//   Shared SOC definitions for the memory-mapped UART transmitter:
//   IO word offsets, STATUS bit positions, transmitter state encoding
//   and a helper that packs the STATUS word.
package uart_tx_mmio_pkg;

  // IO word offsets inside the UART window.
  localparam logic [1:0] IO_DATA   = 2'd0;
  localparam logic [1:0] IO_STATUS = 2'd1;

  // STATUS register bit positions.
  localparam int unsigned ST_BUSY = 0;
  localparam int unsigned ST_FULL = 1;
  localparam int unsigned ST_OVF  = 2;

  // Transmitter state encoding.
  localparam logic [1:0] TX_IDLE  = 2'd0;
  localparam logic [1:0] TX_START = 2'd1;
  localparam logic [1:0] TX_DATA  = 2'd2;
  localparam logic [1:0] TX_STOP  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = TX_IDLE,
    S_START = TX_START,
    S_DATA  = TX_DATA,
    S_STOP  = TX_STOP
  } tx_state_e;

  // Builds the 32-bit STATUS word from its three flags.
  function automatic logic [31:0] pack_status(input logic ovf, input logic full,
                                              input logic busy);
    logic [31:0] s;
    s          = 32'd0;
    s[ST_BUSY] = busy;
    s[ST_FULL] = full;
    s[ST_OVF]  = ovf;
    return s;
  endfunction

endpackage

// File: rtl/uart_tx_mmio_sync_fifo.sv
// sync_fifo
//   Small synchronous FIFO with one extra pointer bit to tell full from
//   empty. dout is combinational from the head entry so a consumer can
//   load it in the same cycle it pops. Pushes while full and pops while
//   empty are ignored; full/empty reflect pre-edge state.
// Ports:
//   clk, resetn : clock, synchronous active-low reset (empties the FIFO)
//   push, din   : write request and data
//   pop         : read request (advances head)
//   dout        : head entry
//   full, empty : occupancy flags
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic             do_push_s;
  logic             do_pop_s;

  // Same slot, opposite lap => full; identical pointers => empty.
  assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                     (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign empty     = (wr_ptr_r == rd_ptr_r);
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;
  assign dout      = mem_r[rd_ptr_r[AW-1:0]];

  // Pointer update with natural wrap of the extra lap bit.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
    end
  end

  // Storage array; contents need no reset since pointers gate visibility.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio
//   Memory-mapped 8N1 UART transmitter. Stores to DATA queue a byte in a
//   small FIFO; the serialiser drains it onto TXD. STATUS reads return
//   {29'b0, ovf, full, busy} one cycle after the read strobe.
// Parameters:
//   CLKS_PER_BIT : clk cycles per UART bit (>= 2)
//   DEPTH        : FIFO entries (power of two, >= 2)
// Ports:
//   clk, resetn  : clock, synchronous active-low reset
//   io_sel       : address decode select
//   io_addr      : word offset (0 DATA, 1 STATUS, 2/3 reserved)
//   io_wdata     : store data
//   io_wstrb     : write strobe (qualified by io_sel)
//   io_rstrb     : read strobe (qualified by io_sel)
//   io_rdata     : registered read data, held between reads
//   TXD          : serial output, idle high
module uart_tx_mmio
  import uart_tx_mmio_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104,
  parameter int DEPTH        = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        io_sel,
  input  logic [1:0]  io_addr,
  input  logic [31:0] io_wdata,
  input  logic        io_wstrb,
  input  logic        io_rstrb,
  output logic [31:0] io_rdata,
  output logic        TXD
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BAUD_ONE  = BW'(1);

  tx_state_e   state_r;
  logic [BW-1:0] baud_r;
  logic [2:0]  bit_cnt_r;
  logic [7:0]  sh_r;
  logic        txd_r;
  logic        ovf_r;
  logic [31:0] rdata_r;

  logic        fifo_full_s;
  logic        fifo_empty_s;
  logic [7:0]  fifo_dout_s;
  logic        pop_s;
  logic        wr_data_s;
  logic        wr_status_s;
  logic        rd_s;
  logic        busy_s;
  logic        baud_last_s;
  logic [31:0] status_s;
  logic        unused_wdata_s;

  assign wr_data_s      = io_sel && io_wstrb && (io_addr == IO_DATA);
  assign wr_status_s    = io_sel && io_wstrb && (io_addr == IO_STATUS);
  assign rd_s           = io_sel && io_rstrb;
  assign busy_s         = !fifo_empty_s || (state_r != S_IDLE);
  assign baud_last_s    = (baud_r == BAUD_LAST);
  assign status_s       = pack_status(ovf_r, fifo_full_s, busy_s);
  assign unused_wdata_s = ^io_wdata[31:8];

  assign io_rdata = rdata_r;
  assign TXD      = txd_r;

  // The serialiser takes the head byte whenever it is idle and data waits.
  always_comb begin
    pop_s = 1'b0;
    if ((state_r == S_IDLE) && !fifo_empty_s) begin
      pop_s = 1'b1;
    end else begin
      pop_s = 1'b0;
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (wr_data_s),
    .din    (io_wdata[7:0]),
    .pop    (pop_s),
    .dout   (fifo_dout_s),
    .full   (fifo_full_s),
    .empty  (fifo_empty_s)
  );

  // Transmitter FSM with baud counter; TXD is registered and set on entry
  // to each bit so the line changes exactly on state/bit boundaries.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r   <= S_IDLE;
      baud_r    <= '0;
      bit_cnt_r <= 3'd0;
      sh_r      <= 8'd0;
      txd_r     <= 1'b1;
    end else begin
      case (state_r)
        S_IDLE: begin
          baud_r <= '0;
          if (!fifo_empty_s) begin
            sh_r      <= fifo_dout_s;
            bit_cnt_r <= 3'd0;
            txd_r     <= 1'b0;
            state_r   <= S_START;
          end else begin
            txd_r <= 1'b1;
          end
        end
        S_START: begin
          if (baud_last_s) begin
            baud_r  <= '0;
            txd_r   <= sh_r[0];
            state_r <= S_DATA;
          end else begin
            baud_r <= baud_r + BAUD_ONE;
          end
        end
        S_DATA: begin
          if (baud_last_s) begin
            baud_r <= '0;
            if (bit_cnt_r == 3'd7) begin
              txd_r   <= 1'b1;
              state_r <= S_STOP;
            end else begin
              // sh_r[1] is the bit that becomes sh_r[0] after this shift.
              sh_r      <= {1'b0, sh_r[7:1]};
              txd_r     <= sh_r[1];
              bit_cnt_r <= bit_cnt_r + 3'd1;
            end
          end else begin
            baud_r <= baud_r + BAUD_ONE;
          end
        end
        S_STOP: begin
          if (baud_last_s) begin
            baud_r  <= '0;
            txd_r   <= 1'b1;
            state_r <= S_IDLE;
          end else begin
            baud_r <= baud_r + BAUD_ONE;
          end
        end
        default: begin
          baud_r  <= '0;
          txd_r   <= 1'b1;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  // Sticky overflow flag: set by a DATA store that finds the FIFO full,
  // cleared by writing 1 to its STATUS bit.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ovf_r <= 1'b0;
    end else if (wr_data_s && fifo_full_s) begin
      ovf_r <= 1'b1;
    end else if (wr_status_s && io_wdata[ST_OVF]) begin
      ovf_r <= 1'b0;
    end else begin
      ovf_r <= ovf_r;
    end
  end

  // Registered read port; STATUS is sampled pre-edge, everything else reads 0.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rdata_r <= 32'd0;
    end else if (rd_s) begin
      case (io_addr)
        IO_STATUS: rdata_r <= status_s;
        default:   rdata_r <= 32'd0;
      endcase
    end else begin
      rdata_r <= rdata_r;
    end
  end

endmodule
